// File: rtl/freq_duty_cfg.sv
// freq_duty_cfg: configuration front-end for the frequency/duty divider.
// Ports: i_clk, i_rst (sync, active-high), i_enable (system enable),
//   i_req_valid/o_req_ready handshake carrying i_div_ratio (N) and
//   i_duty_pct; o_div_count/o_duty_count compare values, o_enable,
//   o_done (config-applied pulse), o_cfg_err (last request illegal).
module freq_duty_cfg #(
  parameter int Count_bits = 16,
  parameter int Pct_bits   = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [Count_bits-1:0] i_div_ratio,
  input  logic [Pct_bits-1:0]   i_duty_pct,
  output logic [Count_bits-1:0] o_div_count,
  output logic [Count_bits-1:0] o_duty_count,
  output logic                  o_enable,
  output logic                  o_done,
  output logic                  o_cfg_err
);

  localparam int W  = Count_bits + Pct_bits;
  localparam int CW = $clog2(W + 1);
  localparam logic [Pct_bits:0] DIVISOR = (Pct_bits + 1)'(100);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    APPLY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_cnt;
  logic [Count_bits-1:0] r_n;
  logic [Pct_bits-1:0]   r_mplier;
  logic [W-1:0]          r_mcand;
  logic [W-1:0]          r_acc;
  logic [Pct_bits-1:0]   r_rem;
  logic                  r_cfg_valid;
  logic [Count_bits-1:0] r_div;
  logic [Count_bits-1:0] r_duty;
  logic                  r_en;
  logic                  r_done;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_legal;
  logic                  w_mul_last;
  logic                  w_div_last;
  logic                  w_cfg_valid_nxt;
  logic [Pct_bits:0]     w_trial;
  logic                  w_qbit;
  logic [Pct_bits-1:0]   w_rem_nxt;
  logic [W-1:0]          w_q_nxt;
  logic [Count_bits-1:0] w_nm1;
  logic [Count_bits-1:0] w_h;
  logic [Count_bits-1:0] w_duty;

  assign o_req_ready  = (r_state == IDLE);
  assign o_div_count  = r_div;
  assign o_duty_count = r_duty;
  assign o_enable     = r_en;
  assign o_done       = r_done;
  assign o_cfg_err    = r_err;

  assign w_xfer  = i_req_valid && (r_state == IDLE);
  assign w_legal = (i_div_ratio >= Count_bits'(2))
                && (i_duty_pct <= Pct_bits'(100));

  assign w_mul_last = (r_cnt == CW'(Pct_bits - 1));
  assign w_div_last = (r_cnt == CW'(W - 1));

  // Restoring divide by 100: the dividend is shifted out of the top of
  // r_acc while quotient bits are shifted into the bottom.
  assign w_trial   = {r_rem, r_acc[W-1]};
  assign w_qbit    = (w_trial >= DIVISOR);
  assign w_rem_nxt = Pct_bits'(w_qbit ? w_trial - DIVISOR : w_trial);
  assign w_q_nxt   = {r_acc[W-2:0], w_qbit};

  // High time clamped to [1, N-1] so both phases are non-empty.
  assign w_nm1 = r_n - Count_bits'(1);

  always_comb begin
    w_h = w_q_nxt[Count_bits-1:0];
    if (w_q_nxt == '0) begin
      w_h = Count_bits'(1);
    end else if (w_q_nxt > W'(w_nm1)) begin
      w_h = w_nm1;
    end
  end

  assign w_duty = w_nm1 - w_h;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cfg_valid_nxt = r_cfg_valid;
    unique case (r_state)
      IDLE: begin
        if (w_xfer && w_legal) begin
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        if (w_mul_last) begin
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        if (w_div_last) begin
          w_state_nxt     = APPLY;
          w_cfg_valid_nxt = 1'b1;
        end
      end
      APPLY: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_n         <= '0;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_cfg_valid <= 1'b0;
      r_div       <= '0;
      r_duty      <= '0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cfg_valid <= w_cfg_valid_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_legal) begin
              r_err    <= 1'b0;
              r_n      <= i_div_ratio;
              r_mplier <= i_duty_pct;
              r_mcand  <= W'(i_div_ratio);
              r_acc    <= '0;
              r_rem    <= '0;
              r_cnt    <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= w_mul_last ? '0 : r_cnt + CW'(1);
        end
        DIV: begin
          r_acc <= w_q_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          // Load on entry to APPLY so counts and o_done appear together.
          if (w_div_last) begin
            r_div  <= w_nm1;
            r_duty <= w_duty;
            r_done <= 1'b1;
          end
        end
        APPLY: begin
        end
        default: begin
        end
      endcase
      // Low while APPLY is current: resyncs the divider to phase 0.
      r_en <= i_enable && w_cfg_valid_nxt && (w_state_nxt != APPLY);
    end
  end

endmodule

// File: tb/tb_freq_duty_cfg.sv
// tb_freq_duty_cfg: self-checking bench for freq_duty_cfg.
// Reference model computes counts directly from N and pct.
module tb_freq_duty_cfg;

  localparam int CB  = 16;
  localparam int PB  = 7;
  localparam int LAT = CB + 2 * PB + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_enable;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [CB-1:0] i_div_ratio;
  logic [PB-1:0] i_duty_pct;
  logic [CB-1:0] o_div_count;
  logic [CB-1:0] o_duty_count;
  logic          o_enable;
  logic          o_done;
  logic          o_cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CB-1:0] e_div  = '0;
  logic [CB-1:0] e_duty = '0;

  freq_duty_cfg #(.Count_bits(CB), .Pct_bits(PB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_div_ratio  (i_div_ratio),
    .i_duty_pct   (i_duty_pct),
    .o_div_count  (o_div_count),
    .o_duty_count (o_duty_count),
    .o_enable     (o_enable),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model(input int n, input int p,
                                output logic [CB-1:0] dv,
                                output logic [CB-1:0] dt);
    longint h;
    h = (longint'(n) * longint'(p)) / 100;
    if (h < 1) h = 1;
    if (h > n - 1) h = n - 1;
    dv = CB'(n - 1);
    dt = CB'(longint'(n) - h - 1);
  endfunction

  // Caller is at a negedge; returns at the negedge after the transfer.
  task automatic send(input int n, input int p, output bit ok);
    int g;
    g = 0;
    i_div_ratio = CB'(n);
    i_duty_pct  = PB'(p);
    i_req_valid = 1'b1;
    while (!o_req_ready && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    ok = o_req_ready;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_div_ratio = CB'($urandom);
    i_duty_pct  = PB'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int en_low);
    cyc    = -1;
    en_low = 0;
    for (int c = 1; c <= 100; c++) begin
      if (o_done) begin
        cyc = c;
        break;
      end
      if (!o_enable) en_low++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_enable    = 1'b1;
    i_req_valid = 1'b0;
    i_div_ratio = '0;
    i_duty_pct  = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if ({o_div_count, o_duty_count, o_enable, o_done, o_cfg_err} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_outs got=%0d/%0d en=%0b done=%0b err=%0b",
               o_div_count, o_duty_count, o_enable, o_done, o_cfg_err);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%0b exp=1", o_req_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int cyc, el;
    send(10, 50, ok);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d exp=%0d", cyc, LAT);
    end
    n_checks++;
    if (o_div_count !== 16'd9 || o_duty_count !== 16'd4) begin
      n_fail++;
      $display("FAIL basic_counts got=%0d/%0d exp=9/4",
               o_div_count, o_duty_count);
    end
    n_checks++;
    if (o_enable !== 1'b0 || o_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_apply en=%0b rdy=%0b exp=0/0",
               o_enable, o_req_ready);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b1 || o_req_ready !== 1'b1 || o_done !== 1'b0)
    begin
      n_fail++;
      $display("FAIL basic_after en=%0b rdy=%0b done=%0b exp=1/1/0",
               o_enable, o_req_ready, o_done);
    end
    e_div  = 16'd9;
    e_duty = 16'd4;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc, el;
    send(10, 30, ok);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT || el !== 0) begin
      n_fail++;
      $display("FAIL b2b1_timing cyc=%0d enlow=%0d exp=%0d/0",
               cyc, el, LAT);
    end
    n_checks++;
    if (o_div_count !== 16'd9 || o_duty_count !== 16'd6
        || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b1_apply got=%0d/%0d en=%0b exp=9/6/0",
               o_div_count, o_duty_count, o_enable);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_req_ready !== 1'b1 || o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b1_after rdy=%0b en=%0b exp=1/1",
               o_req_ready, o_enable);
    end
    send(7, 50, ok);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT || el !== 0) begin
      n_fail++;
      $display("FAIL b2b2_timing cyc=%0d enlow=%0d exp=%0d/0",
               cyc, el, LAT);
    end
    n_checks++;
    if (o_div_count !== 16'd6 || o_duty_count !== 16'd3
        || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b2_apply got=%0d/%0d en=%0b exp=6/3/0",
               o_div_count, o_duty_count, o_enable);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b2_after en=%0b exp=1", o_enable);
    end
    e_div  = 16'd6;
    e_duty = 16'd3;
  endtask

  task automatic test_clamps();
    int tbl [5][4] = '{
      '{4, 0, 3, 2},
      '{4, 100, 3, 0},
      '{65535, 99, 65534, 655},
      '{2, 57, 1, 0},
      '{65535, 100, 65534, 0}
    };
    bit ok;
    int cyc, el;
    for (int i = 0; i < 5; i++) begin
      send(tbl[i][0], tbl[i][1], ok);
      wait_done(cyc, el);
      n_checks++;
      if (cyc !== LAT || o_div_count !== CB'(tbl[i][2])
          || o_duty_count !== CB'(tbl[i][3])) begin
        n_fail++;
        $display("FAIL clamp%0d cyc=%0d got=%0d/%0d exp=%0d/%0d/%0d",
                 i, cyc, o_div_count, o_duty_count,
                 LAT, tbl[i][2], tbl[i][3]);
      end
      e_div  = CB'(tbl[i][2]);
      e_duty = CB'(tbl[i][3]);
      @(negedge i_clk);
    end
  endtask

  task automatic test_illegal();
    int bad [2][2] = '{'{1, 50}, '{5, 101}};
    bit ok;
    int cyc, el, seen;
    logic [CB-1:0] dv, dt;
    for (int i = 0; i < 2; i++) begin
      send(bad[i][0], bad[i][1], ok);
      n_checks++;
      if (o_cfg_err !== 1'b1 || o_req_ready !== 1'b1
          || o_done !== 1'b0 || o_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal%0d err=%0b rdy=%0b done=%0b en=%0b",
                 i, o_cfg_err, o_req_ready, o_done, o_enable);
      end
      seen = 0;
      repeat (4) begin
        @(negedge i_clk);
        if (o_done) seen++;
      end
      n_checks++;
      if (seen !== 0 || o_div_count !== e_div
          || o_duty_count !== e_duty) begin
        n_fail++;
        $display("FAIL illegal%0d_hold done=%0d got=%0d/%0d exp=%0d/%0d",
                 i, seen, o_div_count, o_duty_count, e_div, e_duty);
      end
    end
    send(6, 50, ok);
    n_checks++;
    if (o_cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear err=%0b exp=0", o_cfg_err);
    end
    model(6, 50, dv, dt);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT || o_div_count !== dv || o_duty_count !== dt) begin
      n_fail++;
      $display("FAIL illegal_next cyc=%0d got=%0d/%0d exp=%0d/%0d/%0d",
               cyc, o_div_count, o_duty_count, LAT, dv, dt);
    end
    e_div  = dv;
    e_duty = dt;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc, el, seen, n, p;
    logic [CB-1:0] dv, dt;
    send(12, 40, ok);
    repeat (14) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_div_count, o_duty_count, o_enable, o_done, o_cfg_err} !== '0)
    begin
      n_fail++;
      $display("FAIL rstmid_outs got=%0d/%0d en=%0b done=%0b err=%0b",
               o_div_count, o_duty_count, o_enable, o_done, o_cfg_err);
    end
    i_rst = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) seen++;
    end
    n_checks++;
    if (seen !== 0 || o_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle done=%0d rdy=%0b exp=0/1",
               seen, o_req_ready);
    end
    n = $urandom_range(2, 65535);
    p = $urandom_range(0, 100);
    model(n, p, dv, dt);
    send(n, p, ok);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT || o_div_count !== dv || o_duty_count !== dt
        || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_req n=%0d p=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d",
               n, p, cyc, o_div_count, o_duty_count, dv, dt);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_en got=%0b exp=1", o_enable);
    end
    e_div  = dv;
    e_duty = dt;
  endtask

  task automatic test_enable();
    bit ok;
    int cyc, el;
    i_enable = 1'b0;
    send(8, 25, ok);
    wait_done(cyc, el);
    n_checks++;
    if (cyc !== LAT || o_div_count !== 16'd7 || o_duty_count !== 16'd5)
    begin
      n_fail++;
      $display("FAIL en_counts cyc=%0d got=%0d/%0d exp=%0d/7/5",
               cyc, o_div_count, o_duty_count, LAT);
    end
    n_checks++;
    if (el !== cyc - 1 || o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low enlow=%0d en=%0b exp=%0d/0",
               el, o_enable, cyc - 1);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL en_stay got=%0b exp=0", o_enable);
    end
    i_enable = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL en_rise got=%0b exp=1", o_enable);
    end
    i_enable = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL en_fall got=%0b exp=0", o_enable);
    end
    i_enable = 1'b1;
    @(negedge i_clk);
    e_div  = 16'd7;
    e_duty = 16'd5;
  endtask

  task automatic test_random();
    bit ok, legal;
    int cyc, el, n, p;
    logic [CB-1:0] dv, dt;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(2, 65535);
        p = $urandom_range(0, 100);
      end else begin
        n = $urandom_range(0, 65535);
        p = $urandom_range(0, 127);
      end
      legal = (n >= 2) && (p <= 100);
      send(n, p, ok);
      if (legal) begin
        model(n, p, dv, dt);
        wait_done(cyc, el);
        n_checks++;
        if (cyc !== LAT || o_div_count !== dv || o_duty_count !== dt
            || o_cfg_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd%0d n=%0d p=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d",
                   i, n, p, cyc, o_div_count, o_duty_count, dv, dt);
        end
        e_div  = dv;
        e_duty = dt;
        @(negedge i_clk);
      end else begin
        n_checks++;
        if (o_cfg_err !== 1'b1 || o_div_count !== e_div
            || o_duty_count !== e_duty || o_done !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd%0d_bad n=%0d p=%0d err=%0b got=%0d/%0d",
                   i, n, p, o_cfg_err, o_div_count, o_duty_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clamps();
    test_illegal();
    test_reset_mid();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
